// File: rtl/branch_cond_unit.sv
// branch_cond_unit: ALU flag register, branch condition evaluation, registered PC redirect and flush window.
// Optional macro BRANCH_STATS_EN adds saturating taken_cnt / nottaken_cnt outputs.
module branch_cond_unit #(
    parameter int PC_W      = 8,
    parameter int FLUSH_CYC = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      flag_in,
    input  logic            flag_we,
    input  logic            stall,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_pc,
    input  logic [7:0]      br_off,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            flush,
    output logic [3:0]      flags_q
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]     taken_cnt,
    output logic [15:0]     nottaken_cnt
`endif
);
    typedef enum logic {IDLE, FLUSH} state_t;
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d, flags_d, eff;
    logic            redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0] redirect_pc_q, redirect_pc_d, target;
    logic [PC_W+7:0] off_ext;
    logic [7:0]      cond_vec;
    logic            flag_cap, accept, taken;

    // handshake, bypassed flags, condition lookup and branch target
    always_comb begin
        flag_cap = flag_we & ~stall;
        accept   = br_valid & (state_q == IDLE) & ~stall;
        br_ready = (state_q == IDLE) & ~stall & rst_n;
        eff      = flag_cap ? flag_in : flags_q;
        flags_d  = eff;
        cond_vec = {1'b0, eff[0], eff[1], ~eff[2], eff[2], ~eff[3], eff[3], 1'b1};
        taken    = cond_vec[br_cond];
        off_ext  = {{PC_W{br_off[7]}}, br_off};
        target   = br_pc + PC_W'(1) + off_ext[PC_W-1:0];
    end

    // redirect / flush sequencing: one-cycle redirect pulse, then FLUSH_CYC cycles of flush
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (state_q == FLUSH) begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else cnt_d = cnt_q - 4'd1;
        end else if (accept && taken) begin
            state_d          = FLUSH;
            cnt_d            = 4'(FLUSH_CYC - 1);
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= 4'd0;
            flags_q          <= 4'h0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            flags_q          <= flags_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt_q, taken_cnt_d, nottaken_cnt_q, nottaken_cnt_d;

    // saturating per-outcome counters of accepted branches
    always_comb begin
        taken_cnt_d    = taken_cnt_q + 16'(accept & taken & ~&taken_cnt_q);
        nottaken_cnt_d = nottaken_cnt_q + 16'(accept & ~taken & ~&nottaken_cnt_q);
    end

    // counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt_q    <= 16'd0;
            nottaken_cnt_q <= 16'd0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    assign taken_cnt    = taken_cnt_q;
    assign nottaken_cnt = nottaken_cnt_q;
`endif
endmodule

// File: tb/tb_branch_cond_unit.sv
// tb_branch_cond_unit: directed and random checks of branch_cond_unit against a behavioural model.
module tb_branch_cond_unit;
    localparam int PC_W = 8;
    localparam int FLUSH_CYC = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [3:0] flag_in = 4'h0;
    logic flag_we = 1'b0, stall = 1'b0, br_valid = 1'b0;
    logic [2:0] br_cond = 3'd0;
    logic [7:0] br_pc = 8'h0, br_off = 8'h0;
    logic br_ready, redirect_valid, flush;
    logic [7:0] redirect_pc;
    logic [3:0] flags_q;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt, nottaken_cnt;
`endif

    branch_cond_unit #(.PC_W(PC_W), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .flag_in(flag_in), .flag_we(flag_we), .stall(stall),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc),
        .br_off(br_off), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .flags_q(flags_q)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [3:0] m_flags = 4'h0;
    int m_left = 0, m_tk = 0, m_nt = 0;
    bit m_rv = 0, pend = 0;
    logic [7:0] m_rpc = 8'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [2:0] c, input logic [3:0] f);
        bit z = f[3], cy = f[2], b = f[1], p = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return cy;
            3'd4: return !cy;
            3'd5: return b;
            3'd6: return p;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] tgt(input logic [7:0] pc, input logic [7:0] off);
        int t = int'(pc) + 1 + int'($signed(off));
        return 8'(((t % 256) + 256) % 256);
    endfunction

    task automatic chk_outputs();
        chk("flush", flush, m_left > 0);
        chk("redirect_valid", redirect_valid, m_rv);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("flags_q", flags_q, m_flags);
`ifdef BRANCH_STATS_EN
        chk("taken_cnt", taken_cnt, m_tk);
        chk("nottaken_cnt", nottaken_cnt, m_nt);
`endif
    endtask

    task automatic drive(input bit s, input bit fw, input logic [3:0] fi, input bit bv,
                         input logic [2:0] c, input logic [7:0] p, input logic [7:0] o);
        bit exp_ready, acc, tk;
        logic [3:0] eff;
        stall = s; flag_we = fw; flag_in = fi; br_valid = bv; br_cond = c; br_pc = p; br_off = o;
        exp_ready = (m_left == 0) && !s;
        #1 chk("br_ready", br_ready, exp_ready);
        eff = (fw && !s) ? fi : m_flags;
        acc = bv && exp_ready;
        tk = cond_ok(c, eff);
        @(posedge clk);
        m_rv = 0;
        if (m_left > 0) m_left--;
        if (acc && tk) begin
            m_rv = 1;
            m_rpc = tgt(p, o);
            m_left = FLUSH_CYC;
        end
        if (fw && !s) m_flags = fi;
        if (acc && tk && m_tk < 65535) m_tk++;
        if (acc && !tk && m_nt < 65535) m_nt++;
        pend = bv && !acc;
        @(negedge clk);
        chk_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'h0, 0, 3'd0, 8'h0, 8'h0);
    endtask

    initial begin
        bit s, fw, bv;
        logic [3:0] fi;
        logic [2:0] c;
        logic [7:0] p, o;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_br_ready", br_ready, 1'b0);
        chk_outputs();
        rst_n = 1'b1;
        #1 chk("rel_br_ready", br_ready, 1'b1);
        // Z set, branch if Z: 0x10+1+4 = 0x15
        drive(0, 1, 4'b1000, 0, 3'd0, 8'h0, 8'h0);
        drive(0, 0, 4'h0, 1, 3'd1, 8'h10, 8'h04);
        chk("beq_target", redirect_pc, 8'h15);
        chk("beq_pulse", redirect_valid, 1'b1);
        idle(3);
        // bypassed carry flag with wrap-around target
        drive(0, 1, 4'b0100, 1, 3'd3, 8'hFE, 8'h05);
        chk("wrap_target", redirect_pc, 8'h04);
        idle(2);
        // negative offset wrap
        drive(0, 0, 4'h0, 1, 3'd0, 8'h02, 8'hF0);
        chk("neg_target", redirect_pc, 8'hF3);
        idle(2);
        // not taken, then back-to-back accepted branch
        drive(0, 1, 4'b1000, 0, 3'd0, 8'h0, 8'h0);
        drive(0, 0, 4'h0, 1, 3'd2, 8'h20, 8'h01);
        chk("nt_flush", flush, 1'b0);
        drive(0, 0, 4'h0, 1, 3'd0, 8'h30, 8'h02);
        chk("b2b_target", redirect_pc, 8'h33);
        idle(2);
        // stall blocks both flag write and acceptance
        drive(1, 1, 4'b0001, 1, 3'd1, 8'h40, 8'h00);
        chk("stall_flags", flags_q, 4'b1000);
        drive(0, 0, 4'h0, 1, 3'd1, 8'h40, 8'h00);
        chk("unstall_target", redirect_pc, 8'h41);
        // reset during second flush cycle
        drive(0, 0, 4'h0, 0, 3'd0, 8'h0, 8'h0);
        chk("pre_rst_flush", flush, 1'b1);
        rst_n = 1'b0;
        #1;
        m_flags = 4'h0; m_left = 0; m_rv = 0; m_rpc = 8'h0; m_tk = 0; m_nt = 0; pend = 0;
        chk("mid_rst_flush", flush, 1'b0);
        chk("mid_rst_ready", br_ready, 1'b0);
        chk_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel2_br_ready", br_ready, 1'b1);
        // random traffic; producer holds a request until accepted
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 4) == 0);
            fw = $urandom_range(0, 1);
            fi = 4'($urandom);
            if (!pend) begin
                bv = ($urandom_range(0, 2) != 0);
                c = 3'($urandom);
                p = 8'($urandom);
                o = 8'($urandom);
            end
            drive(s, fw, fi, bv, c, p, o);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
Consumer side of the execute-stage ALU flag interface. Latches the 4-bit ALU flag vector and accepts branch requests from decode over a valid/ready handshake. Evaluates each branch condition against the current flags and, when the branch is taken, issues a registered PC redirect followed by a fixed-length pipeline flush window. Sits between the ALU and the fetch/PC logic of the pipelined RISC-8 core.

Parameters:
PC_W, 8, program counter / target width
FLUSH_CYC, 2, cycles flush stays asserted per taken branch (legal range 1..15)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flag_in  in  4  ALU flags: [3]=Z zero, [2]=C carry, [1]=B borrow, [0]=P even parity of result
flag_we  in  1  capture flag_in this cycle
stall  in  1  pipeline stall; freezes flag capture and branch acceptance
br_valid  in  1  branch request valid
br_ready  out  1  unit can accept a branch this cycle
br_cond  in  3  condition code
br_pc  in  PC_W  PC of the branch instruction
br_off  in  8  signed two's-complement offset
redirect_valid  out  1  one-cycle pulse: redirect_pc is valid
redirect_pc  out  PC_W  branch target
flush  out  1  squash younger pipeline stages
flags_q  out  4  architectural flag register

Behaviour:
- Reset (async, rst_n=0): flags_q=4'h0, redirect_valid=0, redirect_pc=0, flush=0, state=IDLE, counter=0. br_ready is 0 while rst_n=0.
- Flag register: flags_q <= flag_in when flag_we=1 and stall=0; otherwise it holds.
- Effective flags: flag_in when flag_we=1 and stall=0 in the same cycle (bypass), else flags_q.
- Condition codes on effective flags:
  - 000 always
  - 001 Z=1
  - 010 Z=0
  - 011 C=1
  - 100 C=0
  - 101 B=1
  - 110 P=1
  - 111 never
- Handshake: br_ready = (state==IDLE) & ~stall & rst_n. A branch is accepted on a cycle where br_valid & br_ready. br_valid is ignored when br_ready=0; the producer holds the request until accepted.
- Target: br_pc + 1 + sign_extend(br_off), truncated to PC_W bits. Wrap-around is modulo 2^PC_W (e.g. 0xFE+1+0x05 -> 0x04; 0x02+1+0xF0 -> 0xF3).
- FSM states: IDLE, FLUSH.
  - IDLE, accepted and taken: next cycle redirect_pc=target, redirect_valid=1 for exactly one cycle, flush=1, state=FLUSH, counter=FLUSH_CYC-1.
  - IDLE, accepted and not taken: no output activity; remain in IDLE; next branch can be accepted the following cycle.
  - FLUSH: flush=1 every cycle. Counter decrements while nonzero; when counter==0, next state is IDLE and flush drops. Total flush high time = FLUSH_CYC cycles, starting at the redirect cycle.
  - stall has no effect on FLUSH counting.
- Latency: acceptance to redirect_valid is 1 cycle. redirect_pc holds its value after the pulse until the next taken branch.
- Simultaneous events: a flag write and a branch in the same non-stalled cycle use the bypassed flag_in. A flag write during FLUSH still updates flags_q.
- Reset mid-FLUSH: flush and redirect_valid clear immediately (asynchronously); the FSM returns to IDLE.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined: adds outputs taken_cnt[15:0] and nottaken_cnt[15:0].
  - Incremented on each accepted taken / not-taken branch respectively.
  - Saturate at 16'hFFFF.
  - Reset to 0.
  - cond 111 counts as not-taken.
- When undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset release, idle -> flags_q=0, flush=0, redirect_valid=0, br_ready=1 in the first cycle after rst_n rises with stall=0.
- flag_we=1, flag_in=4'b1000, then br_valid with cond=001, br_pc=0x10, br_off=0x04 -> redirect_valid pulses 1 cycle later with redirect_pc=0x15; flush high 2 cycles; br_ready=0 during FLUSH.
- Same cycle flag_we=1, flag_in=4'b0100 and br_valid cond=011, br_pc=0xFE, br_off=0x05 -> taken via bypass, redirect_pc=0x04 (wrap).
- flags_q=4'b1000, cond=010 -> not taken, no redirect, flush stays 0; back-to-back branch accepted the next cycle.
- stall=1 with br_valid=1 and flag_we=1 -> br_ready=0, flags_q unchanged; deassert stall -> branch accepted.
- rst_n pulled low during the second FLUSH cycle -> flush=0 immediately; after release, br_ready=1. With BRANCH_STATS_EN: taken_cnt=1, then 0 after reset.
